// File: rtl/blocky_pkg.sv
// Shared types and constants for the lane tracker: lane count, position width,
// tracker FSM encoding and default screen geometry.
package blocky_pkg;

    localparam int LANES        = 5;
    localparam int Y_W          = 10;
    localparam int SCREEN_H_DEF = 480;
    localparam int OBJ_H_DEF    = 64;
    localparam int PLAYER_Y_DEF = 400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        MOVE  = 2'd2,
        CHECK = 2'd3
    } trk_state_t;

    // True only when exactly one lane bit is set.
    function automatic logic is_onehot(input logic [LANES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/obstacle_lane_tracker_lane_slot.sv
// One on-screen object slot (road segment or car): spawns at the top, scrolls
// down by a per-frame step and retires once it reaches the screen bottom.
module lane_slot
    import blocky_pkg::*;
#(
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           spawn,
    input  logic           move,
    input  logic [1:0]     step,
    output logic           on,
    output logic [Y_W-1:0] y
);

    localparam logic [Y_W:0] LIMIT = SCREEN_H[Y_W:0];

    // One bit wider than y so the bottom-edge compare never sees a wrapped sum.
    logic [Y_W:0] sum;
    assign sum = {1'b0, y} + {{(Y_W-1){1'b0}}, step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on <= 1'b0;
            y  <= '0;
        end else if (spawn && !on) begin
            on <= 1'b1;
            y  <= '0;
        end else if (move && on) begin
            if (sum >= LIMIT) begin
                on <= 1'b0;
                y  <= '0;
            end else begin
                y  <= sum[Y_W-1:0];
            end
        end
    end

endmodule

// File: rtl/obstacle_lane_tracker.sv
// Per-frame spawn/scroll/retire of road segments and cars in five lanes, with an
// optional player collision check enabled by the OBSTACLE_COLLIDE_EN macro.
module obstacle_lane_tracker
    import blocky_pkg::*;
#(
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int OBJ_H    = OBJ_H_DEF,
    parameter int PLAYER_Y = PLAYER_Y_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 pause,
    input  logic [LANES-1:0]     path,
    input  logic [2:0]           obstacle_num,
    input  logic [1:0]           speed_data0,
    input  logic [1:0]           speed_data1,
    input  logic [1:0]           speed_data2,
    input  logic [1:0]           speed_data3,
    input  logic [1:0]           speed_data4,
    input  logic [2:0]           player_lane,
    output logic [LANES-1:0]     road_on,
    output logic [LANES-1:0]     car_on,
    output logic [LANES*Y_W-1:0] road_y,
    output logic [LANES*Y_W-1:0] car_y,
    output logic                 busy,
    output logic                 crash
);

    trk_state_t state, state_nxt;
    logic       spawn_en, move_en, check_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Ticks are only accepted from IDLE, so a tick during a frame is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_tick && !pause) state_nxt = SPAWN;
            SPAWN:   state_nxt = MOVE;
            MOVE:    state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spawn_en = (state == SPAWN);
        move_en  = (state == MOVE);
        check_en = (state == CHECK);
        busy     = (state != IDLE);
    end

    logic [1:0]       speed [LANES];
    logic [LANES-1:0] road_spawn;
    logic [Y_W-1:0]   car_y_a [LANES];

    assign speed[0] = speed_data0;
    assign speed[1] = speed_data1;
    assign speed[2] = speed_data2;
    assign speed[3] = speed_data3;
    assign speed[4] = speed_data4;

    assign road_spawn = (spawn_en && is_onehot(path)) ? path : '0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic       car_spawn;
        logic [1:0] car_step;

        assign car_spawn = spawn_en && (obstacle_num == 3'(i));
        assign car_step  = (speed[i] == 2'd0) ? 2'd1 : speed[i];

        lane_slot #(.SCREEN_H(SCREEN_H)) u_road (
            .clk   (clk),
            .rst_n (rst_n),
            .spawn (road_spawn[i]),
            .move  (move_en),
            .step  (2'd1),
            .on    (road_on[i]),
            .y     (road_y[i*Y_W +: Y_W])
        );

        lane_slot #(.SCREEN_H(SCREEN_H)) u_car (
            .clk   (clk),
            .rst_n (rst_n),
            .spawn (car_spawn),
            .move  (move_en),
            .step  (car_step),
            .on    (car_on[i]),
            .y     (car_y_a[i])
        );

        assign car_y[i*Y_W +: Y_W] = car_y_a[i];
    end

`ifdef OBSTACLE_COLLIDE_EN
    localparam int           Y_HI       = PLAYER_Y + OBJ_H;
    localparam logic [Y_W:0] OBJ_H_V    = OBJ_H[Y_W:0];
    localparam logic [Y_W:0] PLAYER_Y_V = PLAYER_Y[Y_W:0];
    localparam logic [Y_W:0] Y_HI_V     = Y_HI[Y_W:0];

    logic           sel_on;
    logic [Y_W-1:0] sel_y;
    logic           hit;

    // Lane values 5..7 match no lane, leaving sel_on low.
    always_comb begin
        sel_on = 1'b0;
        sel_y  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (player_lane == 3'(i)) begin
                sel_on = car_on[i];
                sel_y  = car_y_a[i];
            end
        end
        hit = sel_on
            && (({1'b0, sel_y} + OBJ_H_V) > PLAYER_Y_V)
            && ({1'b0, sel_y} < Y_HI_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crash <= 1'b0;
        else        crash <= check_en && hit;
    end
`else
    logic unused_collide;
    assign unused_collide = ^{player_lane, check_en, OBJ_H[0], PLAYER_Y[0]};
    assign crash = 1'b0;
`endif

endmodule

// File: tb/tb_obstacle_lane_tracker.sv
// Directed bench for obstacle_lane_tracker: reset, spawn/move timing, retire,
// ignored picks, dropped/paused ticks, mid-frame reset and collision pulse.
module tb_obstacle_lane_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        pause;
    logic [4:0]  path;
    logic [2:0]  obstacle_num;
    logic [1:0]  speed_data0, speed_data1, speed_data2, speed_data3, speed_data4;
    logic [2:0]  player_lane;
    logic [4:0]  road_on, car_on;
    logic [49:0] road_y, car_y;
    logic        busy, crash;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef OBSTACLE_COLLIDE_EN
    localparam logic EXP_HIT = 1'b1;
`else
    localparam logic EXP_HIT = 1'b0;
`endif

    obstacle_lane_tracker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .pause        (pause),
        .path         (path),
        .obstacle_num (obstacle_num),
        .speed_data0  (speed_data0),
        .speed_data1  (speed_data1),
        .speed_data2  (speed_data2),
        .speed_data3  (speed_data3),
        .speed_data4  (speed_data4),
        .player_lane  (player_lane),
        .road_on      (road_on),
        .car_on       (car_on),
        .road_y       (road_y),
        .car_y        (car_y),
        .busy         (busy),
        .crash        (crash)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ry(input int i);
        return road_y[i*10 +: 10];
    endfunction

    function automatic logic [9:0] cy(input int i);
        return car_y[i*10 +: 10];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Returns at the sample point of T+1.
    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    // Returns at the sample point of T+4.
    task automatic run_frame();
        tick();
        cycle();
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_tick = 1'b0;
        pause = 1'b0;
        path = 5'b0;
        obstacle_num = 3'd7;
        speed_data0 = 2'd0; speed_data1 = 2'd0; speed_data2 = 2'd0;
        speed_data3 = 2'd0; speed_data4 = 2'd0;
        player_lane = 3'd7;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) cycle();
        n_cmp++; if (road_on !== 5'b0) begin n_bad++; $display("FAIL rst_road_on: got %b want 00000", road_on); end
        n_cmp++; if (car_on !== 5'b0) begin n_bad++; $display("FAIL rst_car_on: got %b want 00000", car_on); end
        n_cmp++; if (road_y !== 50'b0) begin n_bad++; $display("FAIL rst_road_y: got %h want 0", road_y); end
        n_cmp++; if (car_y !== 50'b0) begin n_bad++; $display("FAIL rst_car_y: got %h want 0", car_y); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (crash !== 1'b0) begin n_bad++; $display("FAIL rst_crash: got %b want 0", crash); end
    endtask

    task automatic test_spawn_move();
        do_reset();
        path = 5'b00100; obstacle_num = 3'd3; speed_data3 = 2'd2;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sm_busy_t0: got %b want 0", busy); end
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sm_busy_t1: got %b want 1", busy); end
        n_cmp++; if (road_on !== 5'b0) begin n_bad++; $display("FAIL sm_road_on_t1: got %b want 00000", road_on); end
        cycle();
        path = 5'b0; obstacle_num = 3'd7;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sm_busy_t2: got %b want 1", busy); end
        n_cmp++; if (road_on !== 5'b00100) begin n_bad++; $display("FAIL sm_road_on_t2: got %b want 00100", road_on); end
        n_cmp++; if (car_on !== 5'b01000) begin n_bad++; $display("FAIL sm_car_on_t2: got %b want 01000", car_on); end
        n_cmp++; if (ry(2) !== 10'd0) begin n_bad++; $display("FAIL sm_road_y2_t2: got %0d want 0", ry(2)); end
        cycle();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sm_busy_t3: got %b want 1", busy); end
        n_cmp++; if (road_on !== 5'b00100) begin n_bad++; $display("FAIL sm_road_on_t3: got %b want 00100", road_on); end
        n_cmp++; if (car_on !== 5'b01000) begin n_bad++; $display("FAIL sm_car_on_t3: got %b want 01000", car_on); end
        n_cmp++; if (ry(2) !== 10'd1) begin n_bad++; $display("FAIL sm_road_y2_t3: got %0d want 1", ry(2)); end
        n_cmp++; if (cy(3) !== 10'd2) begin n_bad++; $display("FAIL sm_car_y3_t3: got %0d want 2", cy(3)); end
        cycle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sm_busy_t4: got %b want 0", busy); end
    endtask

    task automatic test_retire();
        do_reset();
        obstacle_num = 3'd4; speed_data4 = 2'd3;
        tick(); cycle();
        obstacle_num = 3'd7;
        cycle(); cycle();
        n_cmp++; if (cy(4) !== 10'd3) begin n_bad++; $display("FAIL ret_y_f1: got %0d want 3", cy(4)); end
        for (int k = 2; k <= 159; k++) begin
            run_frame();
            n_cmp++; if (cy(4) !== 10'(3*k)) begin n_bad++; $display("FAIL ret_y_f%0d: got %0d want %0d", k, cy(4), 3*k); end
        end
        n_cmp++; if (car_on[4] !== 1'b1) begin n_bad++; $display("FAIL ret_on_477: got %b want 1", car_on[4]); end
        run_frame();
        n_cmp++; if (car_on[4] !== 1'b0) begin n_bad++; $display("FAIL ret_on_cleared: got %b want 0", car_on[4]); end
        n_cmp++; if (cy(4) !== 10'd0) begin n_bad++; $display("FAIL ret_y_cleared: got %0d want 0", cy(4)); end
        // Zero speed steps one pixel.
        obstacle_num = 3'd0; speed_data0 = 2'd0;
        tick(); cycle();
        obstacle_num = 3'd7;
        cycle(); cycle();
        n_cmp++; if (cy(0) !== 10'd1) begin n_bad++; $display("FAIL speed0_step: got %0d want 1", cy(0)); end
    endtask

    task automatic test_ignore();
        do_reset();
        path = 5'b00110; obstacle_num = 3'd6;
        run_frame();
        n_cmp++; if (road_on !== 5'b0) begin n_bad++; $display("FAIL ign_multihot: got %b want 00000", road_on); end
        n_cmp++; if (car_on !== 5'b0) begin n_bad++; $display("FAIL ign_obs6: got %b want 00000", car_on); end
        path = 5'b00001; obstacle_num = 3'd0; speed_data0 = 2'd1;
        run_frame();
        n_cmp++; if (ry(0) !== 10'd1) begin n_bad++; $display("FAIL occ_road_f1: got %0d want 1", ry(0)); end
        n_cmp++; if (cy(0) !== 10'd1) begin n_bad++; $display("FAIL occ_car_f1: got %0d want 1", cy(0)); end
        run_frame();
        n_cmp++; if (ry(0) !== 10'd2) begin n_bad++; $display("FAIL occ_road_f2: got %0d want 2", ry(0)); end
        n_cmp++; if (cy(0) !== 10'd2) begin n_bad++; $display("FAIL occ_car_f2: got %0d want 2", cy(0)); end
        n_cmp++; if ({road_on, car_on} !== 10'b00001_00001) begin n_bad++; $display("FAIL occ_on: got %b want 0000100001", {road_on, car_on}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        path = 5'b00001;
        tick(); cycle();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_t3: got %b want 1", busy); end
        cycle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_t4: got %b want 0", busy); end
        cycle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_t5: got %b want 0", busy); end
        n_cmp++; if (ry(0) !== 10'd1) begin n_bad++; $display("FAIL b2b_road_y: got %0d want 1", ry(0)); end
        pause = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pause_busy: got %b want 0", busy); end
        cycle(); cycle(); cycle();
        n_cmp++; if (ry(0) !== 10'd1) begin n_bad++; $display("FAIL pause_road_y: got %0d want 1", ry(0)); end
        pause = 1'b0;
        tick();
        pause = 1'b1;
        cycle(); cycle();
        n_cmp++; if (ry(0) !== 10'd2) begin n_bad++; $display("FAIL pause_mid_road_y: got %0d want 2", ry(0)); end
        cycle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pause_mid_busy: got %b want 0", busy); end
        pause = 1'b0;
        // Asynchronous reset in the middle of a frame.
        tick(); cycle();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (road_on !== 5'b0) begin n_bad++; $display("FAIL midrst_road_on: got %b want 00000", road_on); end
        n_cmp++; if (ry(0) !== 10'd0) begin n_bad++; $display("FAIL midrst_road_y: got %0d want 0", ry(0)); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        cycle();
        rst_n = 1'b1;
        cycle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got %b want 0", busy); end
    endtask

    task automatic test_collide();
        do_reset();
        player_lane = 3'd1; obstacle_num = 3'd1; speed_data1 = 2'd2;
        tick(); cycle();
        obstacle_num = 3'd7;
        cycle(); cycle();
        for (int k = 2; k <= 168; k++) run_frame();
        n_cmp++; if (cy(1) !== 10'd336) begin n_bad++; $display("FAIL col_y336: got %0d want 336", cy(1)); end
        n_cmp++; if (crash !== 1'b0) begin n_bad++; $display("FAIL col_edge336: got %b want 0", crash); end
        run_frame();
        n_cmp++; if (crash !== EXP_HIT) begin n_bad++; $display("FAIL col_338: got %b want %b", crash, EXP_HIT); end
        tick(); cycle(); cycle();
        n_cmp++; if (cy(1) !== 10'd340) begin n_bad++; $display("FAIL col_y340: got %0d want 340", cy(1)); end
        n_cmp++; if (crash !== 1'b0) begin n_bad++; $display("FAIL col_t3: got %b want 0", crash); end
        cycle();
        n_cmp++; if (crash !== EXP_HIT) begin n_bad++; $display("FAIL col_t4: got %b want %b", crash, EXP_HIT); end
        cycle();
        n_cmp++; if (crash !== 1'b0) begin n_bad++; $display("FAIL col_t5: got %b want 0", crash); end
        player_lane = 3'd5;
        run_frame();
        n_cmp++; if (crash !== 1'b0) begin n_bad++; $display("FAIL col_lane5: got %b want 0", crash); end
        player_lane = 3'd0;
        run_frame();
        n_cmp++; if (crash !== 1'b0) begin n_bad++; $display("FAIL col_empty_lane: got %b want 0", crash); end
        player_lane = 3'd1;
        for (int k = 173; k <= 231; k++) run_frame();
        n_cmp++; if (cy(1) !== 10'd462) begin n_bad++; $display("FAIL col_y462: got %0d want 462", cy(1)); end
        n_cmp++; if (crash !== EXP_HIT) begin n_bad++; $display("FAIL col_462: got %b want %b", crash, EXP_HIT); end
        run_frame();
        n_cmp++; if (crash !== 1'b0) begin n_bad++; $display("FAIL col_464: got %b want 0", crash); end
    endtask

    initial begin
        test_reset();
        test_spawn_move();
        test_retire();
        test_ignore();
        test_back_to_back();
        test_collide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
